// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the E stage and the iterative mul/div unit.
// WIDTH must match the WIDTH of the attached muldiv_iter.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide.
// Result lands in {hi,lo} on the last iteration edge; stall covers the run.
module muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] fprod;
  logic [WIDTH:0]   sum, rsh, diff;
  logic [WIDTH-1:0] step_acc, step_sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  always_comb begin
    sgn   = ~bus.op[0];
    mag_a = (sgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (sgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    fprod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    if (sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])) begin
      fprod = -fprod;
    end
  end

  // sh holds the multiplier (mult) or the dividend turning into the quotient
  always_comb begin
    sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
    rsh  = {acc_q, sh_q[WIDTH-1]};
    diff = rsh - {1'b0, opd_q};
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        step_acc = diff[WIDTH-1:0];
        step_sh  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = rsh[WIDTH-1:0];
        step_sh  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = sum[WIDTH:1];
      step_sh  = {sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Divide by zero leaves rem=|a|; the remainder fixup turns it back into a.
  always_comb begin
    prod = {step_acc, step_sh};
    if (neg_q) begin
      prod = -prod;
    end
    if (is_div_q) begin
      fix_lo = (neg_q & ~dz_q) ? -step_sh : step_sh;
      fix_hi = rneg_q ? -step_acc : step_acc;
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          is_div_d = bus.op[1];
          neg_d    = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rneg_d   = sgn & bus.a[WIDTH-1];
          dz_d     = (bus.b == '0);
          cnt_d    = '0;
          if (FAST_MUL && !bus.op[1]) begin
            state_d = DONE;
            hi_d    = fprod[2*WIDTH-1:WIDTH];
            lo_d    = fprod[WIDTH-1:0];
          end else begin
            state_d = RUN;
            acc_d   = '0;
            sh_d    = bus.op[1] ? mag_a : mag_b;
            opd_d   = bus.op[1] ? mag_b : mag_a;
          end
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          sh_d  = step_sh;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            hi_d    = fix_hi;
            lo_d    = fix_lo;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.stall = ~rst & ((state_q == RUN) |
                     ((state_q == IDLE) & bus.start & ~bus.cancel));
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule
